// File: rtl/ex_iter_pkg.sv
// rtl/ex_iter_pkg.sv - opcodes, result classes and divider state encoding for the execute stage
package ex_iter_pkg;

    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

endpackage

// File: rtl/ex_iter_div.sv
// rtl/ex_iter_div.sv - iterative restoring divider, signed/unsigned, one quotient bit per cycle
// Ports: clk, rst (sync, active-high), signed_i, start_i, annul_i, opdata1_i (dividend),
//        opdata2_i (divisor), result_o {hi=remainder, lo=quotient}, ready_o (END cycle),
//        busy_o (divide accepted or in flight; drives the stall request)
module div_iter
    import ex_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo, rem, dvs, dvd_raw;
    logic              neg_q, neg_r, by_zero;

    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] op1_abs, op2_abs;
    logic [DATA_W:0]   rem_shift, rem_diff;
    logic              step_ge;

    always_comb begin
        op1_neg   = signed_i & opdata1_i[DATA_W-1];
        op2_neg   = signed_i & opdata2_i[DATA_W-1];
        op1_abs   = op1_neg ? -opdata1_i : opdata1_i;
        op2_abs   = op2_neg ? -opdata2_i : opdata2_i;
        // Partial remainder shifted left with the next dividend bit brought in.
        rem_shift = {rem, quo[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, dvs};
        step_ge   = rem_shift >= {1'b0, dvs};
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        ready_o   = 1'b0;
        result_o  = '0;
        if (rst || annul_i) begin
            state_nxt = DIV_FREE;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start_i) begin
                        busy_o    = 1'b1;
                        state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: begin
                    busy_o    = 1'b1;
                    state_nxt = DIV_END;
                end
                DIV_ON: begin
                    busy_o = 1'b1;
                    if (cnt == CNT_LAST) state_nxt = DIV_END;
                end
                DIV_END: begin
                    ready_o   = 1'b1;
                    state_nxt = DIV_FREE;
                    // Magnitude result is fixed up here: quotient sign from the operand
                    // signs, remainder sign from the dividend. MIN/-1 wraps naturally.
                    if (by_zero)
                        result_o = {dvd_raw, {DATA_W{1'b1}}};
                    else
                        result_o = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
                end
                default: state_nxt = DIV_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_FREE;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            dvd_raw <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DIV_FREE && start_i && !annul_i) begin
                cnt     <= '0;
                quo     <= op1_abs;
                rem     <= '0;
                dvs     <= op2_abs;
                dvd_raw <= opdata1_i;
                neg_q   <= op1_neg ^ op2_neg;
                neg_r   <= op1_neg;
                by_zero <= (opdata2_i == '0);
            end else if (state == DIV_ON) begin
                cnt <= cnt + 1'b1;
                quo <= {quo[DATA_W-2:0], step_ge};
                rem <= step_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ex_iter.sv
// rtl/ex_iter.sv - execute stage: logic/shift ALU, iterative divider to HI/LO, stall and annul
// Ports: clk, rst (sync, active-high), aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i;
//        wd_o, wreg_o, wdata_o (GPR data), whilo_o, hi_o (remainder), lo_o (quotient), stallreq_o
module ex_iter
    import ex_iter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [REG_AW-1:0]   wd_i,
    input  logic                wreg_i,
    input  logic                annul_i,
    output logic [REG_AW-1:0]   wd_o,
    output logic                wreg_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                whilo_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                stallreq_o
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   logic_res, shift_res;
    logic [SHAMT_W-1:0]  amt;
    logic                div_signed, div_start, div_ready, div_busy;
    logic [2*DATA_W-1:0] div_result;

    always_comb begin
        amt       = reg1_i[SHAMT_W-1:0];
        logic_res = '0;
        shift_res = '0;
        case (aluop_i)
            ALUOP_W'(EXE_AND_OP): logic_res = reg1_i & reg2_i;
            ALUOP_W'(EXE_OR_OP):  logic_res = reg1_i | reg2_i;
            ALUOP_W'(EXE_NOR_OP): logic_res = ~(reg1_i | reg2_i);
            ALUOP_W'(EXE_XOR_OP): logic_res = reg1_i ^ reg2_i;
            ALUOP_W'(EXE_SLL_OP): shift_res = reg2_i << amt;
            ALUOP_W'(EXE_SRL_OP): shift_res = reg2_i >> amt;
            ALUOP_W'(EXE_SRA_OP): shift_res = $signed(reg2_i) >>> amt;
            default: ;
        endcase
    end

    assign div_signed = (aluop_i == ALUOP_W'(EXE_DIV_OP));
    assign div_start  = div_signed || (aluop_i == ALUOP_W'(EXE_DIVU_OP));

    div_iter #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (div_signed),
        .start_i   (div_start),
        .annul_i   (annul_i),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .result_o  (div_result),
        .ready_o   (div_ready),
        .busy_o    (div_busy)
    );

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            if (alusel_i == ALUSEL_W'(EXE_RES_LOGIC))
                wdata_o = logic_res;
            else if (alusel_i == ALUSEL_W'(EXE_RES_SHIFT))
                wdata_o = shift_res;
            // The divider already suppresses busy/ready under annul.
            stallreq_o = div_busy;
            whilo_o    = div_ready;
            hi_o       = div_result[2*DATA_W-1:DATA_W];
            lo_o       = div_result[DATA_W-1:0];
        end
    end

endmodule
